dcache_port_responder: RTL

Responder (cache-side end) of the two-phase dcache request port (`dcache_req_i_t` / `dcache_req_o_t`). It accepts index-phase requests, grants them, takes the tag one or more cycles later, and returns load data from a small direct-mapped word store. Misses and all stores go to a simple single-outstanding memory port. It sits under any port initiator (CPU load unit, prefetcher) and serves as both a lightweight L1 model and a standalone scratch cache.

---
 rtl/ariane_pkg.sv | 26 ++
 rtl/wt_cache_pkg.sv | 30 +++
 rtl/resp_word_array.sv | 79 +++++++
 rtl/dcache_port_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Minimal slice of the core package: dcache request port types
// shared by every port initiator and responder.
package ariane_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

endpackage

// File: rtl/wt_cache_pkg.sv
// Types for the dcache port responder: FSM states and the
// single-outstanding memory port bundles.
package wt_cache_pkg;
    import ariane_pkg::*;

    localparam int unsigned MEM_ADDR_WIDTH = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        MISS_REQ,
        MISS_WAIT,
        WR_REQ
    } resp_state_e;

    typedef struct packed {
        logic                      req;
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [63:0]               wdata;
        logic [7:0]                be;
    } mem_port_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [63:0] rdata;
    } mem_port_rsp_t;

endpackage

// File: rtl/resp_word_array.sv
// Direct-mapped word store: one valid/tag/64-bit word per set,
// registered read, byte-enable write and full-line fill.
module resp_word_array #(
    parameter int unsigned SetWidth = 9,
    parameter int unsigned TagWidth = 44
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [SetWidth-1:0] rd_set,
    input  logic                wr_en,
    input  logic                wr_fill,
    input  logic [SetWidth-1:0] wr_set,
    input  logic [TagWidth-1:0] wr_tag,
    input  logic [7:0]          wr_be,
    input  logic [63:0]         wr_data,
    output logic                rd_valid,
    output logic [TagWidth-1:0] rd_tag,
    output logic [63:0]         rd_data
);

    localparam int unsigned Sets = 1 << SetWidth;

    logic [Sets-1:0]     valid_q;
    logic [TagWidth-1:0] tag_mem [Sets];
    logic [63:0]         data_mem [Sets];

    logic                fwd;
    logic                fwd_valid;
    logic [TagWidth-1:0] fwd_tag;
    logic [63:0]         fwd_data;

    // A read of the set being written sees the new contents.
    always_comb begin
        fwd       = wr_en && (wr_set == rd_set);
        fwd_valid = valid_q[rd_set];
        fwd_tag   = tag_mem[rd_set];
        fwd_data  = data_mem[rd_set];
        if (fwd) begin
            if (wr_fill) begin
                fwd_valid = 1'b1;
                fwd_tag   = wr_tag;
            end
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) fwd_data[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) data_mem[wr_set][8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (wr_fill) tag_mem[wr_set] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_data  <= '0;
        end else if (rd_en) begin
            rd_valid <= fwd_valid;
            rd_tag   <= fwd_tag;
            rd_data  <= fwd_data;
        end
    end

endmodule

// File: rtl/dcache_port_responder.sv
// Cache-side responder of the two-phase dcache request port with a
// direct-mapped word store and a single-outstanding memory port.
module dcache_port_responder
    import ariane_pkg::*;
    import wt_cache_pkg::*;
#(
    parameter int unsigned IndexWidth = DCACHE_INDEX_WIDTH,
    parameter int unsigned TagWidth   = DCACHE_TAG_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_i,
    input  dcache_req_i_t                  req_port_i,
    output dcache_req_o_t                  req_port_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [TagWidth+IndexWidth-1:0] mem_addr_o,
    output logic [63:0]                    mem_wdata_o,
    output logic [7:0]                     mem_be_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [63:0]                    mem_rdata_i
);

    localparam int unsigned SetWidth  = IndexWidth - 3;
    localparam int unsigned AddrWidth = TagWidth + IndexWidth;

    resp_state_e state_q, state_d;

    logic [IndexWidth-1:0] idx_q;
    logic [TagWidth-1:0]   tag_q;
    logic                  we_q;
    logic [63:0]           wdata_q;
    logic [7:0]            be_q;
    logic                  lat_req;
    logic                  lat_tag;

    logic                  rd_en;
    logic                  wr_en;
    logic                  wr_fill;
    logic [7:0]            wr_be;
    logic [63:0]           wr_data;
    logic                  rd_valid;
    logic [TagWidth-1:0]   rd_tag;
    logic [63:0]           rd_data;
    logic                  hit;
    logic                  done;

    mem_port_req_t         mreq;
    mem_port_rsp_t         mrsp;

    logic                  unused_ok;
    assign unused_ok = ^{req_port_i.data_size, idx_q[2:0]};

    assign mrsp.gnt    = mem_gnt_i;
    assign mrsp.rvalid = mem_rvalid_i;
    assign mrsp.rdata  = mem_rdata_i;

    assign hit = rd_valid && (rd_tag == req_port_i.address_tag[TagWidth-1:0]);

    resp_word_array #(
        .SetWidth (SetWidth),
        .TagWidth (TagWidth)
    ) u_array (
        .clk      (clk),
        .rst      (rst_i),
        .rd_en    (rd_en),
        .rd_set   (req_port_i.address_index[IndexWidth-1:3]),
        .wr_en    (wr_en),
        .wr_fill  (wr_fill),
        .wr_set   (idx_q[IndexWidth-1:3]),
        .wr_tag   (tag_q),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (lat_req) begin
                idx_q   <= req_port_i.address_index[IndexWidth-1:0];
                we_q    <= req_port_i.data_we;
                wdata_q <= req_port_i.data_wdata;
                be_q    <= req_port_i.data_be;
            end
            if (lat_tag) tag_q <= req_port_i.address_tag[TagWidth-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        req_port_o = '0;
        mreq.req   = 1'b0;
        mreq.we    = 1'b0;
        lat_req    = 1'b0;
        lat_tag    = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_fill    = 1'b0;
        wr_be      = be_q;
        wr_data    = wdata_q;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                done = 1'b1;
            end
            TAG: begin
                if (req_port_i.tag_valid) begin
                    if (req_port_i.kill_req) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else if (!we_q) begin
                        if (hit) begin
                            req_port_o.data_rvalid = 1'b1;
                            req_port_o.data_rdata  = rd_data;
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            lat_tag = 1'b1;
                            state_d = MISS_REQ;
                        end
                    end else begin
                        // No write-allocate: only resident words are merged.
                        wr_en   = hit;
                        lat_tag = 1'b1;
                        state_d = WR_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mreq.req = 1'b1;
                if (mrsp.gnt) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mrsp.rvalid) begin
                    wr_en   = 1'b1;
                    wr_fill = 1'b1;
                    wr_be   = 8'hFF;
                    wr_data = mrsp.rdata;
                    req_port_o.data_rvalid = 1'b1;
                    req_port_o.data_rdata  = mrsp.rdata;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                mreq.req = 1'b1;
                mreq.we  = 1'b1;
                if (mrsp.gnt) begin
                    req_port_o.data_rvalid = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A completed lookup frees the port for the next index phase.
        if (done && !rst_i) begin
            req_port_o.data_gnt = req_port_i.data_req;
            if (req_port_i.data_req) begin
                rd_en   = 1'b1;
                lat_req = 1'b1;
                state_d = TAG;
            end
        end
    end

    assign mreq.addr  = MEM_ADDR_WIDTH'({tag_q, idx_q[IndexWidth-1:3], 3'b000});
    assign mreq.wdata = wdata_q;
    assign mreq.be    = be_q;

    assign mem_req_o   = mreq.req;
    assign mem_we_o    = mreq.we;
    assign mem_addr_o  = AddrWidth'(mreq.addr);
    assign mem_wdata_o = mreq.wdata;
    assign mem_be_o    = mreq.be;

endmodule
